histogram_equalizer_top: RTL and testbench
==========================================

Name: histogram_equalizer_top

Overview:
- Top level of the histogram-equalizer block. Contains three memories:
  - input image memory, 32-bit words, 4 pixels of 8 bits per word;
  - scratch histogram memory, 128-bit words, four 32-bit bins per word;
  - output memory.
- On a start pulse it clears the histogram, builds a 256-bin histogram of the image in scratch memory, then writes the cumulative distribution (CDF) to output memory.
- Histogram write-port signals are brought out so the bench can compare them against the software model.

Parameters:
- ADDR_W, 16, address width of all three memories (depth 2^ADDR_W).
- BIN_W, 32, width of one histogram bin / CDF count.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- new_image_pulse  input  1  start request, sampled high for at least one clock.
- input_mem_depth  input  17  number of input words to process (0..65536).
- scratch_mem_depth  input  17  scratch depth; writes at address >= this value are suppressed.
- output_mem_depth  input  17  output depth; writes at address >= this value are suppressed.
- hist_we  output  1  scratch write enable.
- hist_waddr  output  16  scratch write address.
- hist_wdata  output  128  scratch write data; bin j is bits [32j+31:32j].
- busy  output  1  high from start until completion.
- done  output  1  one-cycle pulse when the CDF is finished.

Behaviour:
- Memories:
  - All three are synchronous: write at the clock edge, registered read with 1-cycle latency.
  - Input memory instance is input_memory_u0; its array Register is 65536x32 and is preloaded by backdoor.
  - Memory contents are not affected by reset.
- Reset (reset low, asynchronous): FSM goes to IDLE; hist_we, hist_waddr, hist_wdata, busy, done, running sum and all counters go to 0.
- IDLE:
  - Waits for new_image_pulse=1, then enters CLEAR and raises busy.
  - new_image_pulse is ignored while busy=1.
- CLEAR: 64 cycles. Cycle k asserts hist_we=1, hist_waddr=k, hist_wdata=0, for k=0..63.
- FETCH:
  - If word counter = input_mem_depth, go to CDF.
  - Otherwise issue an input read at the word counter; data is used next cycle.
  - Pixel p of the word (p=0..3) is bits [8p+7:8p], processed in order p=0 to 3.
- Per pixel, two states:
  - HRD: issue scratch read at pixel[7:2].
  - HWR: hist_we=1, hist_waddr=pixel[7:2], hist_wdata = read word with bin pixel[1:0] incremented by 1, modulo 2^32; other bins unchanged.
  - The next HRD follows HWR, so consecutive equal pixels see the updated word and no forwarding is needed.
  - Cost per input word is 9 cycles (FETCH + 4x2); the word counter increments after pixel 3.
- CDF, for k=0..63:
  - CRD: read scratch word k.
  - CWR: write output word k. Bin j = sum + bin0 + ... + binj of word k, with sum = running total of all previous bins.
  - The running sum is 32-bit and wraps.
- Completion:
  - After k=63, done=1 for exactly one cycle and busy drops in the same cycle; return to IDLE.
  - Total cycles from start = 64 + 9*input_mem_depth + (input_mem_depth==0 ? 1 : 1) + 128.
- hist_* outputs are registered-equivalent: stable from shortly after the rising edge for the whole write cycle. hist_we=0 in all non-write states.
- Depth limits: a write whose address is >= the corresponding *_mem_depth does not modify memory. hist_we is still driven, for observability.
- Reset asserted mid-operation aborts immediately; the next start re-clears the histogram.

Test Plan:
- Reset checks: hold reset=0 for 3 cycles, release, no pulse -> busy=0, hist_we=0, done=0 indefinitely.
- Single word: input word 0 = 0x03020100, input_mem_depth=1, pulse -> 64 clear writes, then writes to address 0 with:
  - wdata 0x...0000_0001 after pixel 0;
  - bins {0,0,1,1} after pixel 1;
  - bins {0,1,1,1} after pixel 2;
  - bins {1,1,1,1} after pixel 3.
  - Output word 0 = {4,3,2,1}; output words 1..63 = {4,4,4,4}; done after 64+9+1+128 cycles.
- Repeated pixel: word 0xFFFFFFFF, depth 1 -> four writes to address 63, bin3 = 1,2,3,4; output word 63 bin3 = 4.
- Empty image: input_mem_depth=0 -> only clear writes; all output words = 0; done pulse.
- Busy guard: pulse again mid-histogram -> ignored; results identical to single-pulse run.
- Reset mid-run: assert reset during HWR -> outputs 0 at once; a new pulse restarts with 64 clear writes.

Source files
------------

// File: rtl/histogram_equalizer_top_if.sv
// Control and histogram write-port bundle of the histogram equalizer.
// The DUT takes the slave view; the environment driving start/depths takes the master view.
interface histogram_equalizer_top_if #(
  parameter int ADDR_W = 16,
  parameter int BIN_W  = 32
);
  logic                 new_image_pulse;
  logic [ADDR_W:0]      input_mem_depth;
  logic [ADDR_W:0]      scratch_mem_depth;
  logic [ADDR_W:0]      output_mem_depth;
  logic                 hist_we;
  logic [ADDR_W-1:0]    hist_waddr;
  logic [4*BIN_W-1:0]   hist_wdata;
  logic                 busy;
  logic                 done;

  modport master (
    output new_image_pulse, input_mem_depth, scratch_mem_depth, output_mem_depth,
    input  hist_we, hist_waddr, hist_wdata, busy, done
  );

  modport slave (
    input  new_image_pulse, input_mem_depth, scratch_mem_depth, output_mem_depth,
    output hist_we, hist_waddr, hist_wdata, busy, done
  );
endinterface

// File: rtl/histogram_equalizer_top.sv
// Histogram equalizer: clears a 256-bin histogram, accumulates it from an 8-bit
// pixel image, then writes the 32-bit cumulative distribution to output memory.

module hist_ram #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] Register [2**ADDR_W];

  // NOTE: memories carry no reset; their contents must survive a reset and a
  // reset term would stop the array from mapping onto RAM.
  always_ff @(posedge clock) begin
    if (we) Register[waddr] <= wdata;
    rdata <= Register[raddr];
  end
endmodule

module histogram_equalizer_top #(
  parameter int ADDR_W = 16,
  parameter int BIN_W  = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  histogram_equalizer_top_if.slave   io
);
  localparam int WORD_W  = 4 * BIN_W;
  localparam int DEPTH_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_HRD, S_HWR, S_CRD, S_CWR, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [5:0]           idx_q;
  logic [1:0]           pix_q;
  logic [DEPTH_W-1:0]   word_cnt_q;
  logic [BIN_W-1:0]     sum_q;

  logic [31:0]          in_rdata;
  logic [WORD_W-1:0]    scr_rdata;
  logic [WORD_W-1:0]    out_rdata_unused;
  logic [7:0]           pixel;
  logic [WORD_W-1:0]    inc_word;
  logic [WORD_W-1:0]    cdf_word;
  logic [BIN_W-1:0]     cdf_acc;

  logic                 hist_we;
  logic [ADDR_W-1:0]    hist_waddr;
  logic [WORD_W-1:0]    hist_wdata;
  logic                 out_write;
  logic [ADDR_W-1:0]    scr_raddr;
  logic                 scr_we;
  logic                 out_we;

  // The input word stays on the read port for all four pixels because the
  // word counter only advances after pixel 3.
  hist_ram #(.ADDR_W(ADDR_W), .DATA_W(32)) input_memory_u0 (
    .clock (clock),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .raddr (word_cnt_q[ADDR_W-1:0]),
    .rdata (in_rdata)
  );

  hist_ram #(.ADDR_W(ADDR_W), .DATA_W(WORD_W)) scratch_memory_u0 (
    .clock (clock),
    .we    (scr_we),
    .waddr (hist_waddr),
    .wdata (hist_wdata),
    .raddr (scr_raddr),
    .rdata (scr_rdata)
  );

  hist_ram #(.ADDR_W(ADDR_W), .DATA_W(WORD_W)) output_memory_u0 (
    .clock (clock),
    .we    (out_we),
    .waddr (ADDR_W'(idx_q)),
    .wdata (cdf_word),
    .raddr ('0),
    .rdata (out_rdata_unused)
  );

  assign pixel     = in_rdata[{pix_q, 3'b000} +: 8];
  assign scr_raddr = (state_q == S_CRD) ? ADDR_W'(idx_q) : ADDR_W'(pixel[7:2]);

  // Writes past the configured depth are dropped, but hist_we stays visible.
  assign scr_we = hist_we   && ({1'b0, hist_waddr}     < io.scratch_mem_depth);
  assign out_we = out_write && ({1'b0, ADDR_W'(idx_q)} < io.output_mem_depth);

  always_comb begin
    inc_word = scr_rdata;
    inc_word[int'(pixel[1:0]) * BIN_W +: BIN_W] =
      scr_rdata[int'(pixel[1:0]) * BIN_W +: BIN_W] + BIN_W'(1);
  end

  // NOTE: blocking assignments here build a combinational prefix-sum chain;
  // each bin sees the accumulator value updated by the previous iteration.
  always_comb begin
    cdf_acc  = sum_q;
    cdf_word = '0;
    for (int j = 0; j < 4; j++) begin
      cdf_acc                        = cdf_acc + scr_rdata[j*BIN_W +: BIN_W];
      cdf_word[j*BIN_W +: BIN_W]     = cdf_acc;
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    hist_we    = 1'b0;
    hist_waddr = '0;
    hist_wdata = '0;
    out_write  = 1'b0;
    unique case (state_q)
      S_IDLE:  if (io.new_image_pulse) state_d = S_CLEAR;
      S_CLEAR: begin
        hist_we    = 1'b1;
        hist_waddr = ADDR_W'(idx_q);
        if (idx_q == 6'd63) state_d = S_FETCH;
      end
      S_FETCH: state_d = (word_cnt_q == io.input_mem_depth) ? S_CRD : S_HRD;
      S_HRD:   state_d = S_HWR;
      S_HWR: begin
        hist_we    = 1'b1;
        hist_waddr = ADDR_W'(pixel[7:2]);
        hist_wdata = inc_word;
        state_d    = (pix_q == 2'd3) ? S_FETCH : S_HRD;
      end
      S_CRD:   state_d = S_CWR;
      S_CWR: begin
        out_write = 1'b1;
        if (idx_q == 6'd63) state_d = S_DONE;
        else                state_d = S_CRD;
      end
      S_DONE:  state_d = io.new_image_pulse ? S_CLEAR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      pix_q      <= '0;
      word_cnt_q <= '0;
      sum_q      <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          idx_q      <= '0;
          pix_q      <= '0;
          word_cnt_q <= '0;
          sum_q      <= '0;
        end
        S_CLEAR: idx_q <= idx_q + 6'd1;
        S_HWR: begin
          pix_q <= pix_q + 2'd1;
          if (pix_q == 2'd3) word_cnt_q <= word_cnt_q + DEPTH_W'(1);
        end
        S_CWR: begin
          idx_q <= idx_q + 6'd1;
          sum_q <= cdf_acc;
        end
        default: ;
      endcase
    end
  end

  assign io.hist_we    = hist_we;
  assign io.hist_waddr = hist_waddr;
  assign io.hist_wdata = hist_wdata;
  assign io.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign io.done       = (state_q == S_DONE);
endmodule

// File: tb/tb_histogram_equalizer_top.sv
// Directed bench for histogram_equalizer_top: clear sequence, per-pixel
// histogram writes, CDF contents, depth limits, busy guard and mid-run reset.
module tb_histogram_equalizer_top;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  histogram_equalizer_top_if io ();
  histogram_equalizer_top dut (.clock(clock), .reset(reset), .io(io));

  int n_checks = 0;
  int n_fail   = 0;

  int            wr_a[$];
  logic [127:0]  wr_d[$];
  int            wr_c[$];
  int            done_cyc;
  int            busy_bad;
  int            exp_wa[$];
  logic [127:0]  exp_wd[$];
  logic [127:0]  exp_out[64];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] w4(input int b3, input int b2, input int b1, input int b0);
    return {b3[31:0], b2[31:0], b1[31:0], b0[31:0]};
  endfunction

  // Pulses start, then logs every histogram write with its cycle index
  // (cycle 0 = first CLEAR cycle) until done.
  task automatic run_image(input int glitch_at);
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    done_cyc = -1;
    busy_bad = 0;
    @(negedge clock); io.new_image_pulse = 1'b1;
    @(negedge clock); io.new_image_pulse = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c == glitch_at)          io.new_image_pulse = 1'b1;
      else if (c == glitch_at + 1) io.new_image_pulse = 1'b0;
      if (io.hist_we) begin
        wr_a.push_back(int'(io.hist_waddr));
        wr_d.push_back(io.hist_wdata);
        wr_c.push_back(c);
      end
      if (io.done) begin
        done_cyc = c;
        check("busy_low_at_done", io.busy, 1'b0);
        break;
      end
      if (!io.busy) busy_bad++;
      @(negedge clock);
    end
    io.new_image_pulse = 1'b0;
    @(negedge clock);
    check("done_one_cycle", io.done, 1'b0);
    check("idle_after_done", io.busy, 1'b0);
  endtask

  task automatic verify_run(input string tag, input int n_words);
    int bad = 0;
    check({tag, "_done_cycle"}, done_cyc, 193 + 9 * n_words);
    check({tag, "_busy_held"}, busy_bad, 0);
    check({tag, "_write_count"}, wr_a.size(), 64 + exp_wa.size());
    for (int k = 0; k < 64 && k < wr_a.size(); k++)
      if (wr_a[k] != k || wr_d[k] !== '0 || wr_c[k] != k) bad++;
    check({tag, "_clear_writes"}, bad, 0);
    for (int i = 0; i < exp_wa.size(); i++) begin
      if (64 + i < wr_a.size()) begin
        check($sformatf("%s_waddr_%0d", tag, i), wr_a[64+i], exp_wa[i]);
        check($sformatf("%s_wdata_%0d", tag, i), wr_d[64+i], exp_wd[i]);
        check($sformatf("%s_wcyc_%0d", tag, i), wr_c[64+i], 66 + 9 * (i / 4) + 2 * (i % 4));
      end
    end
    for (int k = 0; k < 64; k++)
      check($sformatf("%s_out_%0d", tag, k), dut.output_memory_u0.Register[k], exp_out[k]);
  endtask

  task automatic expect_single_word(input int out_limit);
    exp_wa = '{0, 0, 0, 0};
    exp_wd = '{w4(0,0,0,1), w4(0,0,1,1), w4(0,1,1,1), w4(1,1,1,1)};
    for (int k = 0; k < 64; k++) exp_out[k] = (k < out_limit) ? w4(4,4,4,4) : '0;
    exp_out[0] = w4(4,3,2,1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    io.new_image_pulse   = 1'b0;
    io.input_mem_depth   = 17'd1;
    io.scratch_mem_depth = 17'h10000;
    io.output_mem_depth  = 17'h10000;

    // Reset held, then released with no start: everything stays quiet.
    repeat (3) begin
      @(negedge clock);
      check("reset_outputs", {io.busy, io.hist_we, io.done}, 3'b000);
    end
    reset = 1'b1;
    repeat (10) begin
      @(negedge clock);
      check("idle_quiet", {io.busy, io.hist_we, io.done}, 3'b000);
    end

    // Single word with four distinct pixels in bin word 0.
    dut.input_memory_u0.Register[0] = 32'h0302_0100;
    io.input_mem_depth = 17'd1;
    expect_single_word(64);
    run_image(-1);
    verify_run("single", 1);

    // Repeated pixel 0xFF: bin 3 of word 63 counts 1..4.
    dut.input_memory_u0.Register[0] = 32'hFFFF_FFFF;
    exp_wa = '{63, 63, 63, 63};
    exp_wd = '{w4(1,0,0,0), w4(2,0,0,0), w4(3,0,0,0), w4(4,0,0,0)};
    for (int k = 0; k < 64; k++) exp_out[k] = '0;
    exp_out[63] = w4(4,0,0,0);
    run_image(-1);
    verify_run("repeat", 1);

    // Two words: second word adds four more hits on bin 0.
    dut.input_memory_u0.Register[0] = 32'h0302_0100;
    dut.input_memory_u0.Register[1] = 32'h0000_0000;
    io.input_mem_depth = 17'd2;
    exp_wa = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_wd = '{w4(0,0,0,1), w4(0,0,1,1), w4(0,1,1,1), w4(1,1,1,1),
               w4(1,1,1,2), w4(1,1,1,3), w4(1,1,1,4), w4(1,1,1,5)};
    for (int k = 0; k < 64; k++) exp_out[k] = w4(8,8,8,8);
    exp_out[0] = w4(8,7,6,5);
    run_image(-1);
    verify_run("two_words", 2);

    // Empty image: only clear writes, CDF all zero.
    io.input_mem_depth = 17'd0;
    exp_wa.delete(); exp_wd.delete();
    for (int k = 0; k < 64; k++) exp_out[k] = '0;
    run_image(-1);
    verify_run("empty", 0);

    // Output depth 32: words 32..63 keep the zeros from the empty run.
    io.input_mem_depth  = 17'd1;
    io.output_mem_depth = 17'd32;
    expect_single_word(32);
    run_image(-1);
    verify_run("out_limit", 1);
    io.output_mem_depth = 17'h10000;

    // Second start pulse during the histogram phase is ignored.
    expect_single_word(64);
    run_image(66);
    verify_run("busy_guard", 1);

    // Reset during the second pixel write, then a clean restart.
    @(negedge clock); io.new_image_pulse = 1'b1;
    @(negedge clock); io.new_image_pulse = 1'b0;
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      if (io.hist_we && c >= 64) cnt++;
      if (cnt == 2) break;
      @(negedge clock);
    end
    check("abort_point_reached", cnt, 2);
    reset = 1'b0;
    #1;
    check("abort_hist_we", io.hist_we, 1'b0);
    check("abort_busy", io.busy, 1'b0);
    check("abort_waddr", io.hist_waddr, '0);
    check("abort_wdata", io.hist_wdata, '0);
    @(negedge clock);
    reset = 1'b1;
    run_image(-1);
    verify_run("after_abort", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
